rv32_shifter_arbiter: RTL

//  Shares one rv32_barrel_shifter between two requesters, e.g. the integer issue

---
 rtl/rv32_shifter_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rv32_shifter_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_shifter_arbiter: round-robin sharing of one RV32 barrel shifter between
// two requesters, with a one-entry valid/ready result register.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rv32_shifter_arbiter #(
  parameter int TAG_W   = 4,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_instr,
  input  logic [31:0]      req0_rs1,
  input  logic [31:0]      req0_rs2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_instr,
  input  logic [31:0]      req1_rs1,
  input  logic [31:0]      req1_rs2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             sh_enable,
  output logic             sh_logical,
  output logic             sh_direction,
  output logic             sh_immediate,
  output logic [31:0]      sh_code_bus,
  output logic [31:0]      sh_rs1,
  output logic [31:0]      sh_rs2,
  input  logic [31:0]      sh_rd1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src,
  output logic             res_err
);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic              rr_ptr;
  logic              slot_free;
  logic              grant;
  logic              accept;
  logic              supported;
  logic [2:0]        funct3;
  logic [31:0]       sel_instr;
  logic [31:0]       sel_rs1;
  logic [4:0]        sel_shamt;
  logic [TAG_W-1:0]  sel_tag;
  logic              unused_rs2_hi;

  // Only the low five rs2 bits form a shift amount; the rest are dropped here.
  assign unused_rs2_hi = ^{req0_rs2[31:5], req1_rs2[31:5]};

  // Reset gating keeps readies low so nothing appears accepted during reset.
  always_comb begin
    slot_free = ~reset & ((state == EMPTY) | res_ready);
    if (req0_valid && req1_valid) begin
      grant = rr_ptr;
    end else begin
      grant = req1_valid;
    end
    accept     = slot_free & (req0_valid | req1_valid);
    req0_ready = slot_free & ~grant;
    req1_ready = slot_free & grant;
  end

  always_comb begin
    sel_instr = grant ? req1_instr    : req0_instr;
    sel_rs1   = grant ? req1_rs1      : req0_rs1;
    sel_shamt = grant ? req1_rs2[4:0] : req0_rs2[4:0];
    sel_tag   = grant ? req1_tag      : req0_tag;
    funct3    = sel_instr[14:12];
    supported = (funct3 == 3'b001) | (funct3 == 3'b101);
  end

  always_comb begin
    sh_enable    = 1'b0;
    sh_logical   = 1'b0;
    sh_direction = 1'b0;
    sh_immediate = 1'b0;
    sh_code_bus  = 32'h0;
    sh_rs1       = 32'h0;
    sh_rs2       = 32'h0;
    if (accept && supported) begin
      sh_enable    = 1'b1;
      sh_direction = funct3[2];
      sh_logical   = funct3[2] & ~sel_instr[30];
      sh_immediate = ~sel_instr[5];
      sh_code_bus  = sel_instr;
      sh_rs1       = sel_rs1;
      sh_rs2       = {27'b0, sel_shamt};
    end
  end

  // In FULL an accept implies res_ready, so FULL->FULL is the back-to-back case.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (res_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data <= 32'h0;
      res_tag  <= '0;
      res_src  <= 1'b0;
      res_err  <= 1'b0;
      rr_ptr   <= RR_INIT;
    end else if (accept) begin
      res_data <= supported ? sh_rd1 : 32'h0;
      res_tag  <= sel_tag;
      res_src  <= grant;
      res_err  <= ~supported;
      rr_ptr   <= ~grant;
    end
  end

  assign res_valid = (state == FULL);

endmodule
`default_nettype wire
